// File: rtl/cache_control4way_pkg.sv
// Shared types for the 4-way write-back cache controller: FSM states,
// address-mux encodings, way index type and one-hot/priority helpers.
package cache_types;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    typedef logic [1:0] way_t;

    localparam logic [2:0] ADR_CPU  = 3'd0;
    localparam logic [2:0] ADR_WAY0 = 3'd1;
    localparam logic [2:0] ADR_WAY1 = 3'd2;
    localparam logic [2:0] ADR_WAY2 = 3'd3;
    localparam logic [2:0] ADR_WAY3 = 3'd4;

    // Lowest set bit wins; an all-zero vector maps to way 0.
    function automatic way_t lowest_way(input logic [3:0] vec);
        way_t w;
        casez (vec)
            4'b???1: w = 2'd0;
            4'b??10: w = 2'd1;
            4'b?100: w = 2'd2;
            4'b1000: w = 2'd3;
            default: w = 2'd0;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] way_onehot(input way_t w);
        return 4'b0001 << w;
    endfunction

endpackage

// File: rtl/cache_control4way_victim.sv
// Replacement victim choice: prefer the lowest invalid way, otherwise the
// pseudo-LRU way supplied by the datapath.
module victim_select4way
    import cache_types::*;
(
    input  logic [3:0] valid,
    input  logic [1:0] lru,
    output way_t       way
);

    // Pick the victim for the indexed set.
    always_comb begin
        way = lru;
        if (valid != 4'b1111) begin
            way = lowest_way(~valid);
        end else begin
            way = lru;
        end
    end

endmodule

// File: rtl/cache_control4way.sv
// Control FSM for the 4-way, 8-set write-back data cache: hit service,
// dirty-victim writeback, line fill and saturating performance counters.
module cache_control4way
    import cache_types::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic [3:0]           hit,
    input  logic [3:0]           valid,
    input  logic [3:0]           dirty,
    input  logic [1:0]           lru,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [3:0]           data_writeline,
    output logic [3:0]           tag_write,
    output logic [3:0]           valid_write,
    output logic                 valid_in,
    output logic [3:0]           dirty_write,
    output logic                 dirty_in,
    output logic                 update_lru,
    output logic                 wb_sel,
    output logic [2:0]           adrmux_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_r, state_next_s;
    way_t                 victim_r, victim_next_s, victim_sel_s, hit_way_s;
    logic                 req_s;
    logic                 hit_inc_s, miss_inc_s, wb_inc_s;
    logic [CNT_WIDTH-1:0] hit_count_r, miss_count_r, wb_count_r;

    victim_select4way u_victim (
        .valid (valid),
        .lru   (lru),
        .way   (victim_sel_s)
    );

    assign req_s     = mem_read | mem_write;
    assign hit_way_s = lowest_way(hit);

    // State and victim registers; reset abandons any memory transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            victim_r <= 2'd0;
        end else begin
            state_r  <= state_next_s;
            victim_r <= victim_next_s;
        end
    end

    // Next state and strobes; strobes are held low while reset is asserted.
    always_comb begin
        state_next_s   = state_r;
        victim_next_s  = victim_r;
        hit_inc_s      = 1'b0;
        miss_inc_s     = 1'b0;
        wb_inc_s       = 1'b0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        data_writeline = 4'b0000;
        tag_write      = 4'b0000;
        valid_write    = 4'b0000;
        valid_in       = 1'b0;
        dirty_write    = 4'b0000;
        dirty_in       = 1'b0;
        update_lru     = 1'b0;
        wb_sel         = 1'b0;
        adrmux_sel     = ADR_CPU;
        if (!rst_n) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && (hit != 4'b0000)) begin
                        mem_resp   = 1'b1;
                        update_lru = 1'b1;
                        hit_inc_s  = 1'b1;
                        // Simultaneous read+write is serviced as a write.
                        if (mem_write) begin
                            data_writeline = way_onehot(hit_way_s);
                            wb_sel         = 1'b1;
                            dirty_write    = way_onehot(hit_way_s);
                            dirty_in       = 1'b1;
                        end else begin
                            wb_sel = 1'b0;
                        end
                    end else if (req_s) begin
                        victim_next_s = victim_sel_s;
                        miss_inc_s    = 1'b1;
                        if (valid[victim_sel_s] && dirty[victim_sel_s]) begin
                            state_next_s = ST_WRITEBACK;
                            wb_inc_s     = 1'b1;
                        end else begin
                            state_next_s = ST_FILL;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_WRITEBACK: begin
                    pmem_write = 1'b1;
                    adrmux_sel = ADR_WAY0 + {1'b0, victim_r};
                    if (pmem_resp) begin
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_WRITEBACK;
                    end
                end
                ST_FILL: begin
                    pmem_read  = 1'b1;
                    adrmux_sel = ADR_CPU;
                    // Install the clean line; the retried request then hits.
                    if (pmem_resp) begin
                        data_writeline = way_onehot(victim_r);
                        tag_write      = way_onehot(victim_r);
                        valid_write    = way_onehot(victim_r);
                        valid_in       = 1'b1;
                        dirty_write    = way_onehot(victim_r);
                        dirty_in       = 1'b0;
                        state_next_s   = ST_IDLE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters, bumped on the transition cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= '0;
            miss_count_r <= '0;
            wb_count_r   <= '0;
        end else begin
            if (hit_inc_s && (hit_count_r != CNT_MAX)) begin
                hit_count_r <= hit_count_r + CNT_ONE;
            end
            if (miss_inc_s && (miss_count_r != CNT_MAX)) begin
                miss_count_r <= miss_count_r + CNT_ONE;
            end
            if (wb_inc_s && (wb_count_r != CNT_MAX)) begin
                wb_count_r <= wb_count_r + CNT_ONE;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;

endmodule

// File: doc/cache_control4way.md
Name: cache_control4way

Overview:
- Control FSM for the 4-way, 8-set, 128-bit-line write-back data cache; sits directly upstream of the 4-way cache datapath and drives all of its write enables and selects.
- Turns CPU read/write requests into hit service, dirty-victim writeback and line fill over the physical-memory handshake.
- Carries saturating hit/miss/writeback performance counters.

Parameters:
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  CPU request complete (one-cycle pulse)
hit  in  4  per-way hit from datapath {hit3..hit0}
valid  in  4  per-way valid of indexed set
dirty  in  4  per-way dirty of indexed set
lru  in  2  pseudo-LRU way of indexed set
pmem_read  out  1  line read request to physical memory
pmem_write  out  1  line write request to physical memory
pmem_resp  in  1  physical memory done (one-cycle pulse)
data_writeline  out  4  per-way data array write
tag_write  out  4  per-way tag write
valid_write  out  4  per-way valid write
valid_in  out  1  valid bit value
dirty_write  out  4  per-way dirty write
dirty_in  out  1  dirty bit value
update_lru  out  1  touch pseudo-LRU for the current set
wb_sel  out  1  0 = line from pmem_rdata, 1 = CPU-merged line
adrmux_sel  out  3  0 = mem_address, 1+w = {tag of way w, index}
hit_count  out  CNT_WIDTH  saturating request-hit count
miss_count  out  CNT_WIDTH  saturating miss count
wb_count  out  CNT_WIDTH  saturating writeback count

Behaviour:
- Reset (rst_n low, async): state IDLE, victim reg 0, all counters 0; all outputs 0 (adrmux_sel 0, wb_sel 0). Reset mid-WRITEBACK/FILL abandons the transaction immediately.
- All strobe outputs are Moore/Mealy combinational from state + inputs; default 0 every cycle.
- States: IDLE, WRITEBACK, FILL.
- IDLE, no request: all strobes 0, stay.
- IDLE, request, |hit: way w = lowest set hit bit (multi-hit is illegal; lowest wins). Same cycle: mem_resp=1, update_lru=1, hit_count++.
  - Write hit additionally: data_writeline[w]=1, wb_sel=1, dirty_write[w]=1, dirty_in=1.
  - Stay IDLE. Zero added latency.
- IDLE, request, no hit: victim = lowest invalid way if any valid bit is 0, else lru. Victim is registered. miss_count++.
  - If victim valid and dirty: go to WRITEBACK; wb_count++.
  - Else go to FILL.
  - mem_resp=0.
- WRITEBACK: pmem_write=1, adrmux_sel=1+victim. On pmem_resp, go to FILL.
  - The datapath evicts by lru. The victim equals lru whenever writeback occurs, because an invalid way is never dirty-written back.
- FILL: pmem_read=1, adrmux_sel=0. On pmem_resp, same cycle:
  - data_writeline[victim]=1, wb_sel=0, tag_write[victim]=1.
  - valid_write[victim]=1, valid_in=1, dirty_write[victim]=1, dirty_in=0.
  - Go to IDLE. The retried request then hits: read miss takes fill + 1 cycle; write miss merges on that hit cycle.
- mem_read and mem_write together: treated as write.
- Request dropped during WRITEBACK/FILL: the transaction still completes; no mem_resp is issued afterwards unless the request is present in IDLE.
- pmem_resp outside WRITEBACK/FILL: ignored.
- Counters saturate at all-ones; no wrap. Increment on the transition cycle only. A retried hit after a miss also counts as a hit.

Decomposition:
- Package cache_types: state enum, adrmux encodings (ADR_CPU=0, ADR_WAY0..3=1..4), 2-bit way typedef, CNT_WIDTH default.
- Sub-module: victim_select4way, combinational; inputs valid[3:0] and lru, outputs a 2-bit way.

Test Plan:
- Reset with rst_n=0 mid-FILL -> all outputs 0, state IDLE, counters 0 within the same cycle, no clock needed.
- Read hit with hit=4'b0100 -> same-cycle mem_resp=1, update_lru=1, no writes, hit_count 0->1.
- Write hit with hit=4'b0001 -> data_writeline=0001, wb_sel=1, dirty_write=0001, dirty_in=1, mem_resp=1.
- Read miss, valid=1011, dirty=1111, lru=0 -> victim 2, FILL directly (no pmem_write), pmem_read until pmem_resp after 5 cycles; then tag/valid/data writes on way 2, dirty_in=0.
- Write miss, valid=1111, dirty=0010, lru=1 -> WRITEBACK with adrmux_sel=2, pmem_write held until pmem_resp, then FILL, then merged write hit; wb_count=1, miss_count=1.
- Force 2^CNT_WIDTH+3 hits (CNT_WIDTH=4 override, 19 hits) -> hit_count holds 4'hF.
